// File: rtl/adc_config_pkg.sv
// Shared definitions for the ADC configuration command queue.
package adc_config_pkg;

    localparam int CFG_ADDR_W      = 3;
    localparam int CFG_DATA_W      = 16;
    localparam int CFG_ENTRY_W     = CFG_ADDR_W + CFG_DATA_W;
    localparam int DEF_ACK_TIMEOUT = 4;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_ACK  = 2'd1,
        SEQ_XFER = 2'd2
    } seq_state_e;

    // Queue entries hold the address in the upper bits and the data below it.
    function automatic logic [CFG_ENTRY_W-1:0] pack_entry(
        input logic [CFG_ADDR_W-1:0] addr,
        input logic [CFG_DATA_W-1:0] data
    );
        return {addr, data};
    endfunction

endpackage

// File: rtl/adc_config_queue_if.sv
// Write-post and three-wire mux handshake signals of the ADC config queue.
interface adc_config_queue_if;
    import adc_config_pkg::*;

    logic                  wr_en;
    logic [CFG_ADDR_W-1:0] wr_addr;
    logic [CFG_DATA_W-1:0] wr_data;
    logic                  config_busy_i;
    logic                  config_start_o;
    logic [CFG_ADDR_W-1:0] config_addr_o;
    logic [CFG_DATA_W-1:0] config_data_o;

    // Register interface and mux side (posts writes, reports busy).
    modport master (
        output wr_en, wr_addr, wr_data, config_busy_i,
        input  config_start_o, config_addr_o, config_data_o
    );

    // The queue itself.
    modport slave (
        input  wr_en, wr_addr, wr_data, config_busy_i,
        output config_start_o, config_addr_o, config_data_o
    );

endinterface

// File: rtl/adc_config_fifo.sv
// Synchronous FIFO with flush; fill/full/empty are registered.
module adc_config_fifo
    import adc_config_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = CFG_ENTRY_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    input  logic [WIDTH-1:0]       wdata_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic [$clog2(DEPTH):0] fill_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic                   empty_nxt_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] fill_q, fill_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             do_push_s;
    logic             do_pop_s;

    // A push is judged against the current fill, so a same-cycle pop never makes room.
    always_comb begin
        do_push_s = push_i && !full_q && !flush_i;
        do_pop_s  = pop_i && !empty_q && !flush_i;
    end

    // Next pointer and occupancy; flush discards everything still stored.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            fill_d   = '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   fill_d = fill_q + CNT_W'(1);
                2'b01:   fill_d = fill_q - CNT_W'(1);
                default: fill_d = fill_q;
            endcase
        end
        empty_d = (fill_d == CNT_W'(0));
        full_d  = (fill_d == CNT_W'(DEPTH));
    end

    // Pointer and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage array; contents need no reset because the pointers gate every read.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o     = mem_q[rd_ptr_q];
    assign fill_o      = fill_q;
    assign full_o      = full_q;
    assign empty_o     = empty_q;
    assign empty_nxt_o = rst ? 1'b1 : empty_d;

endmodule

// File: rtl/adc_config_queue.sv
// Buffers ADC register writes and issues them one by one to the config mux.
module adc_config_queue
    import adc_config_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   rst,
    adc_config_queue_if.slave      bus,
    input  logic                   enable,
    input  logic                   flush,
    input  logic                   status_clr,
    output logic                   request_o,
    output logic [$clog2(DEPTH):0] fill_o,
    output logic                   empty_o,
    output logic                   full_o,
    output logic                   idle_o,
    output logic                   overflow_o,
    output logic                   ack_err_o,
    output logic [15:0]            xfer_count_o
);

    localparam int TMR_W = $clog2(ACK_TIMEOUT + 1) + 1;

    seq_state_e            state_q, state_d;
    logic [TMR_W-1:0]      tmr_q, tmr_d;
    logic                  request_q, request_d;
    logic                  start_q, start_d;
    logic [CFG_ADDR_W-1:0] addr_q, addr_d;
    logic [CFG_DATA_W-1:0] data_q, data_d;
    logic                  ovf_q, ovf_d;
    logic                  aerr_q, aerr_d;
    logic [15:0]           cnt_q, cnt_d;
    logic                  idle_q, idle_d;

    logic                  issue_s;
    logic                  done_s;
    logic                  ack_to_s;
    logic                  wr_drop_s;
    logic [CFG_ENTRY_W-1:0] head_s;
    logic                  fifo_full_s;
    logic                  fifo_empty_s;
    logic                  fifo_empty_nxt_s;

    adc_config_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CFG_ENTRY_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (bus.wr_en),
        .pop_i       (issue_s),
        .flush_i     (flush),
        .wdata_i     (pack_entry(bus.wr_addr, bus.wr_data)),
        .rdata_o     (head_s),
        .fill_o      (fill_o),
        .full_o      (fifo_full_s),
        .empty_o     (fifo_empty_s),
        .empty_nxt_o (fifo_empty_nxt_s)
    );

    // Sequencer next state: issue from IDLE, wait for busy in ACK, wait for its fall in XFER.
    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q;
        start_d  = 1'b0;
        addr_d   = addr_q;
        data_d   = data_q;
        issue_s  = 1'b0;
        done_s   = 1'b0;
        ack_to_s = 1'b0;
        case (state_q)
            SEQ_IDLE: begin
                if (!fifo_empty_s && request_q && !bus.config_busy_i && !flush) begin
                    issue_s = 1'b1;
                    start_d = 1'b1;
                    addr_d  = head_s[CFG_ENTRY_W-1:CFG_DATA_W];
                    data_d  = head_s[CFG_DATA_W-1:0];
                    tmr_d   = '0;
                    state_d = SEQ_ACK;
                end else begin
                    state_d = SEQ_IDLE;
                end
            end
            SEQ_ACK: begin
                if (bus.config_busy_i) begin
                    state_d = SEQ_XFER;
                end else if (tmr_q == TMR_W'(ACK_TIMEOUT)) begin
                    // The mux never answered; the entry is abandoned.
                    ack_to_s = 1'b1;
                    state_d  = SEQ_IDLE;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            SEQ_XFER: begin
                if (!bus.config_busy_i) begin
                    done_s  = 1'b1;
                    state_d = SEQ_IDLE;
                end else begin
                    state_d = SEQ_XFER;
                end
            end
            default: begin
                state_d = SEQ_IDLE;
            end
        endcase
    end

    // Sticky flags and completion counter; a new event beats a simultaneous clear.
    always_comb begin
        wr_drop_s = bus.wr_en && fifo_full_s && !flush;
        if (wr_drop_s) begin
            ovf_d = 1'b1;
        end else if (status_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
        if (ack_to_s) begin
            aerr_d = 1'b1;
        end else if (status_clr) begin
            aerr_d = 1'b0;
        end else begin
            aerr_d = aerr_q;
        end
        if (done_s) begin
            cnt_d = status_clr ? 16'd1 : cnt_q + 16'd1;
        end else if (status_clr) begin
            cnt_d = 16'd0;
        end else begin
            cnt_d = cnt_q;
        end
        request_d = enable;
        idle_d    = fifo_empty_nxt_s && (state_d == SEQ_IDLE);
    end

    // Sequencer and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= SEQ_IDLE;
            tmr_q     <= '0;
            request_q <= 1'b0;
            start_q   <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            ovf_q     <= 1'b0;
            aerr_q    <= 1'b0;
            cnt_q     <= 16'd0;
            idle_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            request_q <= request_d;
            start_q   <= start_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            ovf_q     <= ovf_d;
            aerr_q    <= aerr_d;
            cnt_q     <= cnt_d;
            idle_q    <= idle_d;
        end
    end

    assign bus.config_start_o = start_q;
    assign bus.config_addr_o  = addr_q;
    assign bus.config_data_o  = data_q;
    assign request_o          = request_q;
    assign empty_o            = fifo_empty_s;
    assign full_o             = fifo_full_s;
    assign idle_o             = idle_q;
    assign overflow_o         = ovf_q;
    assign ack_err_o          = aerr_q;
    assign xfer_count_o       = cnt_q;

endmodule

// File: tb/tb_adc_config_queue.sv
// Randomized bench for adc_config_queue against a queue-based reference model.
module tb_adc_config_queue;

    localparam int DEPTH = 8;
    localparam int ACK_TIMEOUT = 4;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        flush;
    logic        status_clr;
    logic        request_o;
    logic [3:0]  fill_o;
    logic        empty_o;
    logic        full_o;
    logic        idle_o;
    logic        overflow_o;
    logic        ack_err_o;
    logic [15:0] xfer_count_o;

    adc_config_queue_if bus ();

    adc_config_queue #(
        .DEPTH       (DEPTH),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .enable       (enable),
        .flush        (flush),
        .status_clr   (status_clr),
        .request_o    (request_o),
        .fill_o       (fill_o),
        .empty_o      (empty_o),
        .full_o       (full_o),
        .idle_o       (idle_o),
        .overflow_o   (overflow_o),
        .ack_err_o    (ack_err_o),
        .xfer_count_o (xfer_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: pending writes as a plain queue plus the one in-flight transfer.
    logic [18:0] mq[$];
    bit          m_inflight;
    bit          m_acked;
    int          m_wait;
    bit          m_req;
    bit          m_start;
    logic [2:0]  m_addr;
    logic [15:0] m_data;
    bit          m_ovf;
    bit          m_aerr;
    logic [15:0] m_cnt;

    // Mux behaviour and stimulus knobs.
    int  busy_left = 0;
    bit  last_start = 1'b0;
    bit  mux_resp = 1'b1;
    int  lmin = 1;
    int  lmax = 6;
    int  wr_pct = 0;
    int  auto_pct = 0;
    int  en_tog_pct = 0;
    int  flush_pct = 0;
    int  clr_pct = 0;
    int  rst_pm = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_update();
        bit          full_b;
        bit          issue;
        bit          ovf_ev;
        bit          done_ev;
        bit          aerr_ev;
        logic [18:0] e;
        if (rst) begin
            mq.delete();
            m_inflight = 1'b0;
            m_acked    = 1'b0;
            m_wait     = 0;
            m_req      = 1'b0;
            m_start    = 1'b0;
            m_addr     = 3'd0;
            m_data     = 16'd0;
            m_ovf      = 1'b0;
            m_aerr     = 1'b0;
            m_cnt      = 16'd0;
        end else begin
            full_b  = (mq.size() == DEPTH);
            issue   = !m_inflight && (mq.size() != 0) && m_req && !bus.config_busy_i && !flush;
            ovf_ev  = bus.wr_en && !flush && full_b;
            done_ev = 1'b0;
            aerr_ev = 1'b0;
            if (m_inflight) begin
                if (!m_acked) begin
                    if (bus.config_busy_i) begin
                        m_acked = 1'b1;
                    end else if (m_wait == ACK_TIMEOUT) begin
                        aerr_ev    = 1'b1;
                        m_inflight = 1'b0;
                    end else begin
                        m_wait++;
                    end
                end else if (!bus.config_busy_i) begin
                    done_ev    = 1'b1;
                    m_inflight = 1'b0;
                end
            end
            m_start = issue;
            if (issue) begin
                e          = mq.pop_front();
                m_addr     = e[18:16];
                m_data     = e[15:0];
                m_inflight = 1'b1;
                m_acked    = 1'b0;
                m_wait     = 0;
            end
            if (flush) begin
                mq.delete();
            end else if (bus.wr_en && !full_b) begin
                mq.push_back({bus.wr_addr, bus.wr_data});
            end
            if (ovf_ev) m_ovf = 1'b1;
            else if (status_clr) m_ovf = 1'b0;
            if (aerr_ev) m_aerr = 1'b1;
            else if (status_clr) m_aerr = 1'b0;
            if (done_ev) m_cnt = status_clr ? 16'd1 : m_cnt + 16'd1;
            else if (status_clr) m_cnt = 16'd0;
            m_req = enable;
        end
    endtask

    task automatic compare_all();
        check("fill", 32'(fill_o), 32'(mq.size()));
        check("empty", 32'(empty_o), 32'(mq.size() == 0));
        check("full", 32'(full_o), 32'(mq.size() == DEPTH));
        check("idle", 32'(idle_o), 32'((mq.size() == 0) && !m_inflight));
        check("request", 32'(request_o), 32'(m_req));
        check("start", 32'(bus.config_start_o), 32'(m_start));
        check("addr", 32'(bus.config_addr_o), 32'(m_addr));
        check("data", 32'(bus.config_data_o), 32'(m_data));
        check("overflow", 32'(overflow_o), 32'(m_ovf));
        check("ack_err", 32'(ack_err_o), 32'(m_aerr));
        check("xfer_count", 32'(xfer_count_o), 32'(m_cnt));
    endtask

    // Inputs for the cycle that just began; busy follows a start seen one cycle earlier.
    task automatic drive_next(input bit rnd);
        if (last_start && mux_resp) busy_left = $urandom_range(lmax, lmin);
        last_start = bus.config_start_o;
        if (busy_left > 0) begin
            bus.config_busy_i = 1'b1;
            busy_left--;
        end else begin
            bus.config_busy_i = ($urandom_range(99) < auto_pct);
        end
        if (rnd) begin
            bus.wr_en   = ($urandom_range(99) < wr_pct);
            bus.wr_addr = 3'($urandom);
            bus.wr_data = 16'($urandom);
            if ($urandom_range(99) < en_tog_pct) enable = !enable;
            flush      = ($urandom_range(99) < flush_pct);
            status_clr = ($urandom_range(99) < clr_pct);
            rst        = ($urandom_range(999) < rst_pm);
        end
    endtask

    task automatic step(input bit rnd);
        @(posedge clk);
        model_update();
        #1;
        compare_all();
        drive_next(rnd);
    endtask

    initial begin
        rst               = 1'b1;
        enable            = 1'b0;
        flush             = 1'b0;
        status_clr        = 1'b0;
        bus.wr_en         = 1'b0;
        bus.wr_addr       = 3'd0;
        bus.wr_data       = 16'd0;
        bus.config_busy_i = 1'b0;
        step(1'b0);
        step(1'b0);
        check("rst_empty", 32'(empty_o), 32'd1);
        check("rst_idle", 32'(idle_o), 32'd1);
        check("rst_fill", 32'(fill_o), 32'd0);

        // Single write with a 40-cycle mux transfer.
        rst     = 1'b0;
        enable  = 1'b1;
        lmin    = 40;
        lmax    = 40;
        step(1'b0);
        step(1'b0);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 3'd0;
        bus.wr_data = 16'h7CBC;
        step(1'b0);
        bus.wr_en = 1'b0;
        check("single_c1_start", 32'(bus.config_start_o), 32'd0);
        check("single_c1_fill", 32'(fill_o), 32'd1);
        step(1'b0);
        check("single_c2_start", 32'(bus.config_start_o), 32'd1);
        check("single_c2_addr", 32'(bus.config_addr_o), 32'd0);
        check("single_c2_data", 32'(bus.config_data_o), 32'h7CBC);
        step(1'b0);
        check("single_c3_start", 32'(bus.config_start_o), 32'd0);
        for (int i = 0; i < 45; i++) step(1'b0);
        check("single_count", 32'(xfer_count_o), 32'd1);
        check("single_idle", 32'(idle_o), 32'd1);

        // Randomized phases: normal, burst/overflow, ack timeout, enable toggling,
        // flush/clear heavy, and resets with spontaneous busy.
        for (int p = 0; p < 12; p++) begin
            mux_resp = 1'b1; lmin = 1; lmax = 6; wr_pct = 30; auto_pct = 0;
            en_tog_pct = 0; flush_pct = 0; clr_pct = 2; rst_pm = 0;
            enable = 1'b1;
            case (p % 6)
                0: begin wr_pct = 30; end
                1: begin wr_pct = 90; lmin = 30; lmax = 40; end
                2: begin mux_resp = 1'b0; wr_pct = 15; end
                3: begin en_tog_pct = 10; wr_pct = 40; end
                4: begin flush_pct = 8; clr_pct = 10; wr_pct = 50; lmin = 2; lmax = 10; end
                default: begin rst_pm = 15; auto_pct = 10; wr_pct = 40; end
            endcase
            for (int c = 0; c < 300; c++) step(1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
